// File: rtl/alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_stage                                              |
// | Description : RV32I decode/issue stage for the R32 ALU. Decodes OP, OP-IMM |
// |               and LUI into a 4-bit ALU opcode, selects register or         |
// |               immediate operands and presents them from one registered     |
// |               slot with valid/ready backpressure.                          |
// |               Optional feature macro: R32_ISSUE_BYPASS_EN (writeback       |
// |               bypass at accept and refresh of a held slot).                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_operand_a,
  output logic [XLEN-1:0] o_operand_b,
  output logic [3:0]      o_opcode,
  output logic [4:0]      o_rd,
  output logic            o_illegal
);

  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_f7_zero    = 7'b0000000;
  localparam logic [6:0] c_f7_alt     = 7'b0100000;

  localparam logic [3:0] c_alu_add  = 4'd0;
  localparam logic [3:0] c_alu_sub  = 4'd1;
  localparam logic [3:0] c_alu_xor  = 4'd2;
  localparam logic [3:0] c_alu_or   = 4'd3;
  localparam logic [3:0] c_alu_and  = 4'd4;
  localparam logic [3:0] c_alu_sll  = 4'd5;
  localparam logic [3:0] c_alu_srl  = 4'd6;
  localparam logic [3:0] c_alu_sra  = 4'd7;
  localparam logic [3:0] c_alu_slt  = 4'd8;
  localparam logic [3:0] c_alu_sltu = 4'd9;

  // Instruction fields
  logic [6:0] instr_opc;
  logic [2:0] instr_f3;
  logic [6:0] instr_f7;
  logic [4:0] instr_rs1;
  logic [4:0] instr_rs2;
  logic [4:0] instr_rd;

  assign instr_opc  = i_instr[6:0];
  assign instr_f3   = i_instr[14:12];
  assign instr_f7   = i_instr[31:25];
  assign instr_rs1  = i_instr[19:15];
  assign instr_rs2  = i_instr[24:20];
  assign instr_rd   = i_instr[11:7];

  assign o_rs1_addr = instr_rs1;
  assign o_rs2_addr = instr_rs2;

  // Slot state
  logic            valid_q,   valid_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] op_a_q,    op_a_d;
  logic [XLEN-1:0] op_b_q,    op_b_d;
  logic [3:0]      opcode_q,  opcode_d;
  logic [4:0]      rd_q,      rd_d;

  logic accept;
  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  // Shared funct3 map for OP and OP-IMM; SUB/SRA are refined by funct7 in the decoder
  logic [3:0] base_opcode;
  always_comb begin
    base_opcode = c_alu_add;
    case (instr_f3)
      3'b000:  base_opcode = c_alu_add;
      3'b001:  base_opcode = c_alu_sll;
      3'b010:  base_opcode = c_alu_slt;
      3'b011:  base_opcode = c_alu_sltu;
      3'b100:  base_opcode = c_alu_xor;
      3'b101:  base_opcode = c_alu_srl;
      3'b110:  base_opcode = c_alu_or;
      default: base_opcode = c_alu_and;
    endcase
  end

  // Decode legality, ALU opcode and operand sources
  logic       dec_legal;
  logic [3:0] dec_opcode;
  logic       dec_a_reg;
  logic       dec_b_reg;
  logic       dec_lui;
  always_comb begin
    dec_legal  = 1'b0;
    dec_opcode = c_alu_add;
    dec_a_reg  = 1'b0;
    dec_b_reg  = 1'b0;
    dec_lui    = 1'b0;
    case (instr_opc)
      c_opc_op: begin
        dec_a_reg = 1'b1;
        dec_b_reg = 1'b1;
        if (instr_f7 == c_f7_zero) begin
          dec_legal  = 1'b1;
          dec_opcode = base_opcode;
        end else if (instr_f7 == c_f7_alt && instr_f3 == 3'b000) begin
          dec_legal  = 1'b1;
          dec_opcode = c_alu_sub;
        end else if (instr_f7 == c_f7_alt && instr_f3 == 3'b101) begin
          dec_legal  = 1'b1;
          dec_opcode = c_alu_sra;
        end
      end
      c_opc_op_imm: begin
        dec_a_reg = 1'b1;
        if (instr_f3 == 3'b001) begin
          dec_legal  = (instr_f7 == c_f7_zero);
          dec_opcode = c_alu_sll;
        end else if (instr_f3 == 3'b101) begin
          dec_legal  = (instr_f7 == c_f7_zero) || (instr_f7 == c_f7_alt);
          dec_opcode = (instr_f7 == c_f7_alt) ? c_alu_sra : c_alu_srl;
        end else begin
          dec_legal  = 1'b1;
          dec_opcode = base_opcode;
        end
      end
      c_opc_lui: begin
        dec_legal  = 1'b1;
        dec_opcode = c_alu_add;
        dec_lui    = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef R32_ISSUE_BYPASS_EN
  logic wb_fire;
  logic hold;
  assign wb_fire = i_wb_valid && (i_wb_rd != 5'd0);
  assign hold    = valid_q && !i_ready;
`else
  logic unused_wb;
  assign unused_wb = ^{i_wb_valid, i_wb_rd, i_wb_data, dec_a_reg};
`endif

  // Register operands: x0 reads as zero; a matching writeback overrides the file when bypassing
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  always_comb begin
    rs1_val = (instr_rs1 == 5'd0) ? '0 : i_rs1_data;
    rs2_val = (instr_rs2 == 5'd0) ? '0 : i_rs2_data;
`ifdef R32_ISSUE_BYPASS_EN
    if (wb_fire && i_wb_rd == instr_rs1) rs1_val = i_wb_data;
    if (wb_fire && i_wb_rd == instr_rs2) rs2_val = i_wb_data;
`endif
  end

  // Final operand selection: LUI forces A to zero; B is register, I-immediate or U-immediate
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  assign imm_i = XLEN'($signed(i_instr[31:20]));
  assign imm_u = XLEN'({i_instr[31:12], 12'h000});
  always_comb begin
    dec_a = dec_lui ? '0 : rs1_val;
    if (dec_b_reg)    dec_b = rs2_val;
    else if (dec_lui) dec_b = imm_u;
    else              dec_b = imm_i;
  end

`ifdef R32_ISSUE_BYPASS_EN
  // Source tags kept with the held op so a later writeback can refresh its operands
  logic [4:0] rs1_q,   rs1_d;
  logic [4:0] rs2_q,   rs2_d;
  logic       a_reg_q, a_reg_d;
  logic       b_reg_q, b_reg_d;
`endif

  // Slot next state: drain on out-transfer, load on legal accept, refresh while holding
  always_comb begin
    valid_d   = valid_q;
    illegal_d = accept && !dec_legal;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    opcode_d  = opcode_q;
    rd_d      = rd_q;
`ifdef R32_ISSUE_BYPASS_EN
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    a_reg_d   = a_reg_q;
    b_reg_d   = b_reg_q;
`endif
    if (valid_q && i_ready) valid_d = 1'b0;
    if (accept && dec_legal) begin
      valid_d  = 1'b1;
      op_a_d   = dec_a;
      op_b_d   = dec_b;
      opcode_d = dec_opcode;
      rd_d     = instr_rd;
`ifdef R32_ISSUE_BYPASS_EN
      rs1_d    = instr_rs1;
      rs2_d    = instr_rs2;
      a_reg_d  = dec_a_reg;
      b_reg_d  = dec_b_reg;
    end else if (hold && wb_fire) begin
      if (a_reg_q && rs1_q == i_wb_rd) op_a_d = i_wb_data;
      if (b_reg_q && rs2_q == i_wb_rd) op_b_d = i_wb_data;
`endif
    end
  end

  // Slot registers; reset discards any held op
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      opcode_q  <= 4'd0;
      rd_q      <= 5'd0;
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
    end
  end

`ifdef R32_ISSUE_BYPASS_EN
  // Source tag registers for held-op refresh
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      a_reg_q <= 1'b0;
      b_reg_q <= 1'b0;
    end else begin
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
    end
  end
`endif

  assign o_valid     = valid_q;
  assign o_illegal   = illegal_q;
  assign o_operand_a = op_a_q;
  assign o_operand_b = op_b_q;
  assign o_opcode    = opcode_q;
  assign o_rd        = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_issue_stage                                           |
// | Description : Scoreboard bench for alu_issue_stage: directed examples,     |
// |               hold/backpressure, reset mid-hold and random traffic checked |
// |               against an instruction-level reference model.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_issue_stage;

`ifdef R32_ISSUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_operand_a;
  logic [31:0] o_operand_b;
  logic [3:0]  o_opcode;
  logic [4:0]  o_rd;
  logic        o_illegal;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_instr     (i_instr),
    .o_rs1_addr  (o_rs1_addr),
    .o_rs2_addr  (o_rs2_addr),
    .i_rs1_data  (i_rs1_data),
    .i_rs2_data  (i_rs2_data),
    .i_wb_valid  (i_wb_valid),
    .i_wb_rd     (i_wb_rd),
    .i_wb_data   (i_wb_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_operand_a (o_operand_a),
    .o_operand_b (o_operand_b),
    .o_opcode    (o_opcode),
    .o_rd        (o_rd),
    .o_illegal   (o_illegal)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        a_reg;
    logic        b_reg;
  } op_t;

  op_t q[$];
  int  errors = 0;
  int  checks = 0;

  // Model state seen by the monitor, and effects pending until the next clock edge
  logic        m_valid = 1'b0;
  logic        m_illegal = 1'b0;
  logic        p_valid = 1'b0;
  logic        p_ill = 1'b0;
  logic        p_push = 1'b0;
  logic        p_upd_a = 1'b0;
  logic        p_upd_b = 1'b0;
  logic [31:0] p_upd_data = 32'd0;
  op_t         p_entry;

  // ALU opcode by funct3: ADD SLL SLT SLTU XOR SRL OR AND
  logic [3:0] base_op [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_read(input logic [4:0] a, input logic [31:0] d,
                                           input logic wbv, input logic [4:0] wbrd,
                                           input logic [31:0] wbd);
    if (a == 5'd0) return 32'd0;
    if (BYPASS && wbv && wbrd == a) return wbd;
    return d;
  endfunction

  // Reference decode: returns legality, fills the expected issued op
  function automatic logic model_decode(input logic [31:0] w, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic wbv,
                                        input logic [4:0] wbrd, input logic [31:0] wbd,
                                        output op_t e);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    e = '0;
    e.rd  = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    if (w[6:0] == 7'h33) begin
      e.a_reg = 1'b1;
      e.b_reg = 1'b1;
      e.a = reg_read(e.rs1, d1, wbv, wbrd, wbd);
      e.b = reg_read(e.rs2, d2, wbv, wbrd, wbd);
      if (f7 == 7'h00) begin e.op = base_op[f3]; return 1'b1; end
      if (f7 == 7'h20 && f3 == 3'd0) begin e.op = 4'd1; return 1'b1; end
      if (f7 == 7'h20 && f3 == 3'd5) begin e.op = 4'd7; return 1'b1; end
      return 1'b0;
    end
    if (w[6:0] == 7'h13) begin
      e.a_reg = 1'b1;
      e.a = reg_read(e.rs1, d1, wbv, wbrd, wbd);
      e.b = {{20{w[31]}}, w[31:20]};
      if (f3 == 3'd1) begin e.op = 4'd5; return f7 == 7'h00; end
      if (f3 == 3'd5) begin
        if (f7 == 7'h00) begin e.op = 4'd6; return 1'b1; end
        if (f7 == 7'h20) begin e.op = 4'd7; return 1'b1; end
        return 1'b0;
      end
      e.op = base_op[f3];
      return 1'b1;
    end
    if (w[6:0] == 7'h37) begin
      e.b = {w[31:12], 12'h000};
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Apply the effects of the clock edge that just happened to the model
  task automatic commit();
    op_t t;
    m_valid   = p_valid;
    m_illegal = p_ill;
    if (p_push) q.push_back(p_entry);
    if ((p_upd_a || p_upd_b) && q.size() > 0) begin
      t = q[0];
      if (p_upd_a) t.a = p_upd_data;
      if (p_upd_b) t.b = p_upd_data;
      q[0] = t;
    end
    p_push  = 1'b0;
    p_upd_a = 1'b0;
    p_upd_b = 1'b0;
  endtask

  // One clock of stimulus; computes what the coming edge should do
  task automatic drive_cycle(input logic v, input logic [31:0] w, input logic [31:0] d1,
                             input logic [31:0] d2, input logic rdy, input logic wbv,
                             input logic [4:0] wbrd, input logic [31:0] wbd);
    op_t  e;
    logic legal;
    logic mready;
    logic acc;
    logic xfer;
    @(posedge clk);
    #1;
    commit();
    i_valid    = v;
    i_instr    = w;
    i_rs1_data = d1;
    i_rs2_data = d2;
    i_ready    = rdy;
    i_wb_valid = wbv;
    i_wb_rd    = wbrd;
    i_wb_data  = wbd;
    #1;
    if (!rst_n) begin
      p_valid = 1'b0;
      p_ill   = 1'b0;
      return;
    end
    mready = !m_valid || rdy;
    chk("o_ready", 32'(o_ready), 32'(mready));
    chk("rs1_addr", 32'(o_rs1_addr), 32'(w[19:15]));
    chk("rs2_addr", 32'(o_rs2_addr), 32'(w[24:20]));
    legal   = model_decode(w, d1, d2, wbv, wbrd, wbd, e);
    acc     = v && mready;
    xfer    = m_valid && rdy;
    p_push  = acc && legal;
    p_entry = e;
    p_ill   = acc && !legal;
    p_valid = p_push ? 1'b1 : (xfer ? 1'b0 : m_valid);
    p_upd_data = wbd;
    if (BYPASS && m_valid && !rdy && wbv && wbrd != 5'd0 && q.size() > 0) begin
      p_upd_a = q[0].a_reg && q[0].rs1 == wbrd;
      p_upd_b = q[0].b_reg && q[0].rs2 == wbrd;
    end
  endtask

  task automatic idle(input logic rdy);
    drive_cycle(1'b0, 32'h0000_0013, 32'd0, 32'd0, rdy, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_illegal", 32'(o_illegal), 32'd0);
    chk("rst_operand_a", o_operand_a, 32'd0);
    chk("rst_operand_b", o_operand_b, 32'd0);
    chk("rst_opcode", 32'(o_opcode), 32'd0);
    chk("rst_rd", 32'(o_rd), 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    int          k;
    w   = $urandom;
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    k   = $urandom_range(0, 4);
    f7  = (k < 2) ? 7'h00 : (k < 4) ? 7'h20 : 7'($urandom);
    imm = 12'($urandom);
    k   = $urandom_range(0, 9);
    if (k < 4) begin
      w = {f7, rs2, rs1, f3, rd, 7'h33};
    end else if (k < 7) begin
      if ($urandom_range(0, 1) == 1) imm[11:5] = f7;
      w = {imm, rs1, f3, rd, 7'h13};
    end else if (k == 7) begin
      w = {w[31:12], rd, 7'h37};
    end else if (k == 9) begin
      w = {w[31:7], 7'h00};
    end
    return w;
  endfunction

  // Monitor: compares the presented op against the scoreboard head each cycle
  initial begin
    forever begin
      @(negedge clk);
      chk("o_valid", 32'(o_valid), 32'(m_valid));
      chk("o_illegal", 32'(o_illegal), 32'(m_illegal));
      if (m_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: o_valid=%0b but no expected op queued", o_valid);
        end else begin
          chk("opcode", 32'(o_opcode), 32'(q[0].op));
          chk("operand_a", o_operand_a, q[0].a);
          chk("operand_b", o_operand_b, q[0].b);
          chk("rd", 32'(o_rd), 32'(q[0].rd));
          if (i_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_instr    = 32'd0;
    i_rs1_data = 32'd0;
    i_rs2_data = 32'd0;
    i_ready    = 1'b0;
    i_wb_valid = 1'b0;
    i_wb_rd    = 5'd0;
    i_wb_data  = 32'd0;
    p_entry    = '0;
    #3;
    check_reset_outputs();
    idle(1'b1);
    idle(1'b1);
    rst_n = 1'b1;

    // Worked examples: ADD, SRAI, LUI, illegal zero word
    drive_cycle(1'b1, 32'h0020_81B3, 32'd5, 32'd7, 1'b1, 1'b0, 5'd0, 32'd0);
    drive_cycle(1'b1, 32'h4032_5213, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    drive_cycle(1'b1, 32'hABCD_E2B7, 32'h1234_5678, 32'd9, 1'b1, 1'b0, 5'd0, 32'd0);
    drive_cycle(1'b1, 32'h0000_0000, 32'd1, 32'd2, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Hold for three cycles with a competing word and writebacks to rs1 and x0
    drive_cycle(1'b1, 32'h0020_81B3, 32'd5, 32'd7, 1'b1, 1'b0, 5'd0, 32'd0);
    drive_cycle(1'b1, 32'h4020_8233, 32'd20, 32'd3, 1'b0, 1'b1, 5'd1, 32'h55);
    drive_cycle(1'b1, 32'h4020_8233, 32'd20, 32'd3, 1'b0, 1'b1, 5'd0, 32'h77);
    drive_cycle(1'b1, 32'h4020_8233, 32'd20, 32'd3, 1'b0, 1'b0, 5'd0, 32'd0);
    drive_cycle(1'b1, 32'h4020_8233, 32'd20, 32'd3, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Reset while holding: op is discarded immediately
    drive_cycle(1'b1, 32'h0020_81B3, 32'd11, 32'd12, 1'b1, 1'b0, 5'd0, 32'd0);
    drive_cycle(1'b0, 32'h0000_0013, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    q.delete();
    m_valid = 1'b0;
    m_illegal = 1'b0;
    p_valid = 1'b0;
    p_ill = 1'b0;
    p_push = 1'b0;
    p_upd_a = 1'b0;
    p_upd_b = 1'b0;
    idle(1'b1);
    idle(1'b1);
    rst_n = 1'b1;
    drive_cycle(1'b1, 32'h0020_81B3, 32'd5, 32'd7, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Random traffic with backpressure and writeback activity
    for (int n = 0; n < 400; n++) begin
      drive_cycle(1'($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom,
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom);
    end
    for (int n = 0; n < 4; n++) idle(1'b1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
